// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS subset core (add/sub/and/or/slt, lw/sw/beq/addi/j).
// It has one shared memory port and a 32x32 register file.
module mips_multicycle #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [31:0]       retired
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t            r_state;
    logic              r_started;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_ir, r_a, r_b, r_imm, r_alu, r_mdr, r_retired;
    logic [31:0]       r_rf [32];

    logic [5:0]        w_op, w_funct;
    logic [4:0]        w_rs, w_rt, w_rd, w_waddr;
    logic [31:0]       w_imm_sext, w_alu, w_wdata, w_pc4_ext, w_jump32, w_boff;
    logic [ADDR_W-1:0] w_pc4, w_jump, w_btarget;
    logic              w_legal, w_we_rf;

    assign w_op       = r_ir[31:26];
    assign w_rs       = r_ir[25:21];
    assign w_rt       = r_ir[20:16];
    assign w_rd       = r_ir[15:11];
    assign w_funct    = r_ir[5:0];
    assign w_imm_sext = {{16{r_ir[15]}}, r_ir[15:0]};

    assign w_pc4     = r_pc + ADDR_W'(4);
    assign w_pc4_ext = 32'(w_pc4);
    assign w_jump32  = (w_pc4_ext & 32'hF000_0000) | {4'b0, r_ir[25:0], 2'b00};
    assign w_jump    = w_jump32[ADDR_W-1:0];
    assign w_boff    = {r_imm[29:0], 2'b00};
    assign w_btarget = w_pc4 + w_boff[ADDR_W-1:0];

    assign w_legal = ((w_op == OP_RTYPE) &&
                      (w_funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT})) ||
                     (w_op inside {OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW});

    always_comb begin
        w_alu = r_a + r_imm;
        if (w_op == OP_RTYPE) begin
            case (w_funct)
                FN_SUB:  w_alu = r_a - r_b;
                FN_AND:  w_alu = r_a & r_b;
                FN_OR:   w_alu = r_a | r_b;
                FN_SLT:  w_alu = {31'b0, $signed(r_a) < $signed(r_b)};
                default: w_alu = r_a + r_b;
            endcase
        end
    end

    assign w_waddr = (w_op == OP_RTYPE) ? w_rd : w_rt;
    assign w_wdata = (w_op == OP_LW) ? r_mdr : r_alu;
    assign w_we_rf = (r_state == S_WB) && (w_waddr != 5'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 32; i++) r_rf[i] <= '0;
        end else if (w_we_rf) begin
            r_rf[w_waddr] <= w_wdata;
        end
    end

    // r_started keeps the port quiet until the first edge after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_FETCH;
            r_started <= 1'b0;
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_imm     <= '0;
            r_alu     <= '0;
            r_mdr     <= '0;
            r_retired <= '0;
        end else begin
            r_started <= 1'b1;
            case (r_state)
                S_FETCH: begin
                    if (r_started && mem_ready) begin
                        r_ir    <= mem_rdata;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_a   <= r_rf[w_rs];
                    r_b   <= r_rf[w_rt];
                    r_imm <= w_imm_sext;
                    if (!w_legal) begin
                        r_state <= S_HALT;
                    end else if (w_op == OP_J) begin
                        r_pc      <= w_jump;
                        r_retired <= r_retired + 32'd1;
                        r_state   <= S_FETCH;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_alu <= w_alu;
                    if (w_op == OP_BEQ) begin
                        r_pc      <= (r_a == r_b) ? w_btarget : w_pc4;
                        r_retired <= r_retired + 32'd1;
                        r_state   <= S_FETCH;
                    end else if ((w_op == OP_LW) || (w_op == OP_SW)) begin
                        r_state <= (w_alu[1:0] != 2'b00) ? S_HALT : S_MEM;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (w_op == OP_SW) begin
                            r_pc      <= w_pc4;
                            r_retired <= r_retired + 32'd1;
                            r_state   <= S_FETCH;
                        end else begin
                            r_mdr   <= mem_rdata;
                            r_state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    r_pc      <= w_pc4;
                    r_retired <= r_retired + 32'd1;
                    r_state   <= S_FETCH;
                end
                default: r_state <= S_HALT;
            endcase
        end
    end

    assign mem_req   = r_started && ((r_state == S_FETCH) || (r_state == S_MEM));
    assign mem_we    = (r_state == S_MEM) && (w_op == OP_SW);
    assign mem_addr  = (r_state == S_MEM) ? r_alu[ADDR_W-1:0] : r_pc;
    assign mem_wdata = r_b;
    assign pc        = r_pc;
    assign halted    = (r_state == S_HALT);
    assign retired   = r_retired;
endmodule

// File: tb/tb_mips_multicycle.sv
// Directed bench: small programs run from an instruction ROM at 0x00 and a data RAM at 0x40.
// The memory model has a programmable number of wait states.
module tb_mips_multicycle;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req, mem_we, mem_ready, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, retired;

    mips_multicycle #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
        .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;
    localparam logic [5:0]  ADDI = 6'h08, LW = 6'h23, SW = 6'h2B, BEQ = 6'h04;

    logic [31:0] imem [16];
    logic [31:0] dmem [64];
    logic [31:0] doff;
    logic        dmem_clr = 1'b1;
    int          mem_wait = 0, wait_cnt = 0, wr_cnt = 0, acc_cnt = 0, data_req = 0, cyc = 0;

    assign doff      = mem_addr - 32'h40;
    assign mem_ready = mem_req && (wait_cnt >= mem_wait);

    always_comb begin
        if (mem_addr < 32'h40) mem_rdata = imem[mem_addr[5:2]];
        else                   mem_rdata = dmem[doff[7:2]];
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dmem_clr) begin
            for (int i = 0; i < 64; i++) dmem[i] <= 32'hDEAD_BEEF;
            wait_cnt <= 0; wr_cnt <= 0; acc_cnt <= 0; data_req <= 0;
        end else begin
            if (mem_req && mem_ready) begin
                wait_cnt <= 0;
                acc_cnt  <= acc_cnt + 1;
                if (mem_we) begin
                    dmem[doff[7:2]] <= mem_wdata;
                    wr_cnt <= wr_cnt + 1;
                end
            end else if (mem_req) wait_cnt <= wait_cnt + 1;
            else                  wait_cnt <= 0;
            if (mem_req && (mem_addr >= 32'h40)) data_req <= data_req + 1;
        end
    end

    // Retire timestamps/pc and port stability during wait states, sampled mid-cycle
    int          ret_cyc [32];
    logic [31:0] ret_pc  [32];
    logic [31:0] last_ret = '0, s_addr = '0, s_wd = '0;
    logic        prev_wait = 1'b0, s_we = 1'b0;
    int          stab_err = 0;

    always @(negedge clk) begin
        if (!rst) begin
            last_ret = '0; prev_wait = 1'b0; stab_err = 0;
        end else begin
            if (retired != last_ret) begin
                ret_cyc[retired[4:0]] = cyc;
                ret_pc[retired[4:0]]  = pc;
                last_ret = retired;
            end
            if (prev_wait && mem_req && (mem_addr != s_addr || mem_we != s_we || mem_wdata != s_wd))
                stab_err++;
            prev_wait = mem_req && !mem_ready;
            s_addr = mem_addr; s_we = mem_we; s_wd = mem_wdata;
        end
    end

    int n_checks = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] dur(input int k);
        return 32'(ret_cyc[k] - ret_cyc[k-1]);
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 16; i++) imem[i] = HALT_W;
    endtask

    task automatic start(input int w);
        rst = 1'b0; dmem_clr = 1'b1; mem_wait = w;
        repeat (2) @(negedge clk);
        dmem_clr = 1'b0; rst = 1'b1;
    endtask

    task automatic wait_halt(input string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (halted) break;
        end
        chk({name, "_halted"}, {31'b0, halted}, 32'd1);
    endtask

    typedef struct {
        string       name;
        logic [5:0]  fn;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } alu_vec_t;

    alu_vec_t vecs [11];
    logic     found;

    initial begin
        vecs[0]  = '{"add",      6'h20, 16'd5,     16'd7,     32'd12};
        vecs[1]  = '{"add_wrap", 6'h20, 16'hFFFF,  16'd1,     32'd0};
        vecs[2]  = '{"sub_neg",  6'h22, 16'd0,     16'd1,     32'hFFFF_FFFF};
        vecs[3]  = '{"sub_big",  6'h22, 16'h8000,  16'h7FFF,  32'hFFFF_0001};
        vecs[4]  = '{"and",      6'h24, 16'h0F0F,  16'h00FF,  32'h0000_000F};
        vecs[5]  = '{"and_sx",   6'h24, 16'hFFF0,  16'h0FFF,  32'h0000_0FF0};
        vecs[6]  = '{"or",       6'h25, 16'h0F00,  16'h00F0,  32'h0000_0FF0};
        vecs[7]  = '{"slt_m1",   6'h2A, 16'hFFFF,  16'd1,     32'd1};
        vecs[8]  = '{"slt_rev",  6'h2A, 16'd1,     16'hFFFF,  32'd0};
        vecs[9]  = '{"slt_eq",   6'h2A, 16'd7,     16'd7,     32'd0};
        vecs[10] = '{"slt_ext",  6'h2A, 16'h8000,  16'h7FFF,  32'd1};

        clear_imem();
        repeat (3) @(negedge clk);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_pc",      pc,               32'h0);
        chk("rst_retired", retired,          32'd0);
        chk("rst_halted",  {31'b0, halted},  32'd0);

        // addi/addi/add/sw reference program
        clear_imem();
        imem[0] = enc_i(ADDI, 0, 1, 16'd5);
        imem[1] = enc_i(ADDI, 0, 2, 16'd7);
        imem[2] = enc_r(1, 2, 3, 6'h20);
        imem[3] = enc_i(SW, 0, 3, 16'h40);
        start(0);
        @(negedge clk);
        chk("first_fetch_req",  {31'b0, mem_req}, 32'd1);
        chk("first_fetch_addr", mem_addr,         32'h0);
        wait_halt("prog");
        chk("prog_store",   dmem[0],  32'd12);
        chk("prog_wr_cnt",  32'(wr_cnt),  32'd1);
        chk("prog_acc_cnt", 32'(acc_cnt), 32'd6);
        chk("prog_retired", retired,  32'd4);
        chk("prog_pc",      pc,       32'h10);
        chk("addi_cycles",  dur(2),   32'd4);
        chk("sw_cycles",    dur(4),   32'd4);

        for (int v = 0; v < 11; v++) begin
            clear_imem();
            imem[0] = enc_i(ADDI, 0, 1, vecs[v].a);
            imem[1] = enc_i(ADDI, 0, 2, vecs[v].b);
            imem[2] = enc_r(1, 2, 3, vecs[v].fn);
            imem[3] = enc_i(SW, 0, 3, 16'h40);
            start(0);
            wait_halt(vecs[v].name);
            chk({vecs[v].name, "_result"},  dmem[0], vecs[v].exp);
            chk({vecs[v].name, "_retired"}, retired, 32'd4);
            chk({vecs[v].name, "_pc"},      pc,      32'h10);
            chk({vecs[v].name, "_cycles"},  dur(3),  32'd4);
        end

        // $0 stays zero after addi $0,$0,9
        clear_imem();
        imem[0] = enc_i(ADDI, 0, 0, 16'd9);
        imem[1] = enc_i(SW, 0, 0, 16'h40);
        start(0);
        wait_halt("r0");
        chk("r0_zero", dmem[0], 32'd0);

        // sw then lw with 3 wait states per access
        clear_imem();
        imem[0] = enc_i(ADDI, 0, 1, 16'h55);
        imem[1] = enc_i(SW, 0, 1, 16'h40);
        imem[2] = enc_i(LW, 0, 2, 16'h40);
        imem[3] = enc_i(SW, 0, 2, 16'h44);
        start(3);
        wait_halt("wait");
        chk("wait_store",     dmem[0],           32'h55);
        chk("wait_loaded",    dmem[1],           32'h55);
        chk("wait_sw_cycles", dur(2),            32'd10);
        chk("wait_lw_cycles", dur(3),            32'd11);
        chk("wait_stable",    32'(stab_err),     32'd0);
        chk("wait_wr_cnt",    32'(wr_cnt),       32'd2);

        // beq self-loop taken 3 times, then the instruction is patched to fall through
        clear_imem();
        imem[0] = enc_i(ADDI, 0, 1, 16'd1);
        imem[1] = enc_i(ADDI, 0, 2, 16'd2);
        imem[2] = enc_i(BEQ, 1, 1, 16'hFFFF);
        imem[3] = enc_i(SW, 0, 1, 16'h40);
        start(0);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (retired == 32'd5) begin found = 1'b1; break; end
        end
        chk("loop_reached", {31'b0, found}, 32'd1);
        imem[2] = enc_i(BEQ, 1, 2, 16'hFFFF);
        wait_halt("loop");
        for (int k = 3; k <= 5; k++) begin
            chk("loop_taken_pc",     ret_pc[k], 32'h08);
            chk("loop_taken_cycles", dur(k),    32'd3);
        end
        chk("loop_fall_pc",     ret_pc[6], 32'h0C);
        chk("loop_fall_cycles", dur(6),    32'd3);
        chk("loop_retired",     retired,   32'd7);
        chk("loop_store",       dmem[0],   32'd1);

        // jump over two halt words
        clear_imem();
        imem[0] = enc_i(ADDI, 0, 1, 16'd9);
        imem[1] = {6'h02, 26'h4};
        imem[4] = enc_i(SW, 0, 1, 16'h40);
        start(0);
        wait_halt("jump");
        chk("jump_target", ret_pc[2], 32'h10);
        chk("jump_cycles", dur(2),    32'd2);
        chk("jump_store",  dmem[0],   32'd9);
        chk("jump_retired", retired,  32'd3);
        chk("jump_pc",     pc,        32'h14);

        // misaligned lw halts without a data access
        clear_imem();
        imem[0] = enc_i(LW, 0, 1, 16'h42);
        start(0);
        wait_halt("misalign");
        chk("misalign_pc",       pc,              32'h0);
        chk("misalign_retired",  retired,         32'd0);
        chk("misalign_data_req", 32'(data_req),   32'd0);
        chk("misalign_accesses", 32'(acc_cnt),    32'd1);
        chk("misalign_req_low",  {31'b0, mem_req}, 32'd0);

        // reset while a store waits on mem_ready
        clear_imem();
        imem[0] = enc_i(ADDI, 0, 1, 16'd3);
        imem[1] = enc_i(SW, 0, 1, 16'h40);
        start(3);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mem_req && mem_we) begin found = 1'b1; break; end
        end
        chk("rstmid_found",   {31'b0, found}, 32'd1);
        chk("rstmid_pre_ret", retired,        32'd1);
        rst = 1'b0;
        #1;
        chk("rstmid_req",     {31'b0, mem_req}, 32'd0);
        chk("rstmid_pc",      pc,               32'h0);
        chk("rstmid_retired", retired,          32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_fetch_req",  {31'b0, mem_req}, 32'd1);
        chk("rstmid_fetch_addr", mem_addr,         32'h0);
        chk("rstmid_fetch_we",   {31'b0, mem_we},  32'd0);
        wait_halt("rstmid");
        chk("rstmid_final_ret", retired, 32'd2);
        chk("rstmid_store",     dmem[0], 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
